os_classifier: RTL

Receive-path stage directly downstream of the ordered-set decoder. Takes each lane-aligned Gen1/Gen2 ordered set (byte-interleaved across active lanes) and classifies it as TS1, TS2, SKP, EIOS or other. Extracts the training-set fields and checks them for cross-lane consistency. Keeps the saturating consecutive-identical TS1/TS2 counts that the LTSSM uses for state transitions.

---
 rtl/os_pkg.sv | 40 ++++
 rtl/os_lane_extract.sv | 26 ++
 rtl/os_classifier.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/os_pkg.sv
// Shared constants, type encodings and lane helpers for the ordered-set classifier.
package os_pkg;

    localparam int unsigned SYMS   = 16;
    localparam int unsigned SYM_W  = 8;
    localparam int unsigned BODY_W = SYM_W * (SYMS - 1);

    localparam logic [7:0] SYM_COM    = 8'hBC;
    localparam logic [7:0] SYM_PAD    = 8'hF7;
    localparam logic [7:0] SYM_TS1_ID = 8'h4A;
    localparam logic [7:0] SYM_TS2_ID = 8'h45;
    localparam logic [7:0] SYM_SKP    = 8'h1C;
    localparam logic [7:0] SYM_IDL    = 8'h7C;

    typedef enum logic [2:0] {
        OS_NONE  = 3'd0,
        OS_TS1   = 3'd1,
        OS_TS2   = 3'd2,
        OS_SKP   = 3'd3,
        OS_EIOS  = 3'd4,
        OS_OTHER = 3'd7
    } os_type_e;

    // Sixteen symbols of one lane, symbol k at [k]
    typedef logic [SYMS-1:0][SYM_W-1:0] lane_syms_t;

    // log2 of the active lane count; unsupported widths fall back to x1
    function automatic logic [2:0] lane_shift(input logic [4:0] n);
        logic [2:0] s;
        case (n)
            5'd2:    s = 3'd1;
            5'd4:    s = 3'd2;
            5'd8:    s = 3'd3;
            5'd16:   s = 3'd4;
            default: s = 3'd0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/os_lane_extract.sv
// De-interleaves the 16 symbols belonging to one lane from the aligned ordered-set bus.
module os_lane_extract
    import os_pkg::*;
#(
    parameter int unsigned MAX_LANES = 16,
    parameter int unsigned LANE      = 0
) (
    input  logic [128*MAX_LANES-1:0] i_data,
    input  logic [4:0]               i_num_lanes,
    output lane_syms_t               o_syms
);

    localparam int unsigned IDX_W = $clog2(SYMS * MAX_LANES);

    logic [2:0] w_shift;

    assign w_shift = lane_shift(i_num_lanes);

    // Symbol k of this lane sits at byte k*N + LANE
    for (genvar k = 0; k < SYMS; k++) begin : g_sym
        logic [IDX_W-1:0] w_idx;
        assign w_idx     = IDX_W'((k << w_shift) + LANE);
        assign o_syms[k] = i_data[{w_idx, 3'b000} +: SYM_W];
    end

endmodule

// File: rtl/os_classifier.sv
// Classifies lane-aligned ordered sets, checks TS cross-lane consistency and
// tracks consecutive identical TS1/TS2 counts for the LTSSM.
module os_classifier
    import os_pkg::*;
#(
    parameter int unsigned MAX_LANES = 16,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [4:0]               numberOfDetectedLanes,
    input  logic [128*MAX_LANES-1:0] os_data,
    input  logic                     os_valid,
    input  logic                     clear_counts,
    output logic                     out_valid,
    output logic [2:0]               os_type,
    output logic [7:0]               link_num,
    output logic [7:0]               lane_num,
    output logic [7:0]               n_fts,
    output logic [7:0]               rate_id,
    output logic [7:0]               train_ctrl,
    output logic                     link_pad,
    output logic                     lane_pad,
    output logic                     lanes_consistent,
    output logic [CNT_W-1:0]         ts1_count,
    output logic [CNT_W-1:0]         ts2_count,
    output logic                     ts1_rcvd8,
    output logic                     ts2_rcvd8
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    lane_syms_t           w_syms [MAX_LANES];
    logic [MAX_LANES-1:0] w_act;
    logic [2:0]           w_shift;

    logic w_com_ok, w_all_ts1, w_all_ts2, w_all_skp, w_all_idl;
    logic w_same, w_all_pad, w_seq;
    logic w_is_ts, w_consistent, w_hist_ok, w_ident, w_hist_valid_nxt;
    os_type_e            w_type;
    logic [BODY_W-1:0]   w_body;
    logic [CNT_W-1:0]    w_ts1_base, w_ts2_base, w_ts1_nxt, w_ts2_nxt;

    logic              r_out_valid;
    os_type_e          r_os_type;
    logic [7:0]        r_link_num, r_lane_num, r_n_fts, r_rate_id, r_train_ctrl;
    logic              r_link_pad, r_lane_pad, r_consistent;
    logic [CNT_W-1:0]  r_ts1_count, r_ts2_count;
    logic              r_ts1_rcvd8, r_ts2_rcvd8;
    logic              r_hist_valid;
    os_type_e          r_hist_type;
    logic [BODY_W-1:0] r_hist_body;

    for (genvar l = 0; l < MAX_LANES; l++) begin : g_lane
        os_lane_extract #(
            .MAX_LANES (MAX_LANES),
            .LANE      (l)
        ) u_extract (
            .i_data      (os_data),
            .i_num_lanes (numberOfDetectedLanes),
            .o_syms      (w_syms[l])
        );
    end

    assign w_shift = lane_shift(numberOfDetectedLanes);

    // A lane takes part in the checks only when it is below the active width
    always_comb begin
        for (int l = 0; l < MAX_LANES; l++) begin
            w_act[l] = ((l >> w_shift) == 0);
        end
    end

    // Per-type pattern checks and TS field agreement reduced across active lanes
    always_comb begin
        w_com_ok  = 1'b1;
        w_all_ts1 = 1'b1;
        w_all_ts2 = 1'b1;
        w_all_skp = 1'b1;
        w_all_idl = 1'b1;
        w_same    = 1'b1;
        w_all_pad = 1'b1;
        w_seq     = 1'b1;
        for (int l = 0; l < MAX_LANES; l++) begin
            if (w_act[l]) begin
                if (w_syms[l][0] != SYM_COM) w_com_ok = 1'b0;
                for (int k = 6; k < SYMS; k++) begin
                    if (w_syms[l][k] != SYM_TS1_ID) w_all_ts1 = 1'b0;
                    if (w_syms[l][k] != SYM_TS2_ID) w_all_ts2 = 1'b0;
                end
                for (int k = 1; k < 4; k++) begin
                    if (w_syms[l][k] != SYM_SKP) w_all_skp = 1'b0;
                    if (w_syms[l][k] != SYM_IDL) w_all_idl = 1'b0;
                end
                if ((w_syms[l][1] != w_syms[0][1]) || (w_syms[l][3] != w_syms[0][3]) ||
                    (w_syms[l][4] != w_syms[0][4]) || (w_syms[l][5] != w_syms[0][5]))
                    w_same = 1'b0;
                if (w_syms[l][2] != SYM_PAD) w_all_pad = 1'b0;
                if (w_syms[l][2] != (w_syms[0][2] + 8'(l))) w_seq = 1'b0;
            end
        end
    end

    // Final type, consistency and comparison against the stored previous TS
    always_comb begin
        w_type = OS_OTHER;
        if (w_com_ok) begin
            if (w_all_ts1)      w_type = OS_TS1;
            else if (w_all_ts2) w_type = OS_TS2;
            else if (w_all_skp) w_type = OS_SKP;
            else if (w_all_idl) w_type = OS_EIOS;
        end
        w_is_ts      = (w_type == OS_TS1) || (w_type == OS_TS2);
        w_consistent = !w_is_ts || (w_same && (w_seq || w_all_pad));
        w_body       = w_syms[0][SYMS-1:1];
        w_hist_ok    = r_hist_valid && !clear_counts;
        w_ident      = w_hist_ok && (r_hist_type == w_type) &&
                       (r_hist_body == w_body) && w_consistent;
    end

    // Counter and history next state; a same-cycle clear empties history first
    always_comb begin
        w_ts1_base       = clear_counts ? '0 : r_ts1_count;
        w_ts2_base       = clear_counts ? '0 : r_ts2_count;
        w_ts1_nxt        = w_ts1_base;
        w_ts2_nxt        = w_ts2_base;
        w_hist_valid_nxt = w_hist_ok;
        if (os_valid) begin
            case (w_type)
                OS_TS1: begin
                    if (w_ident)
                        w_ts1_nxt = (w_ts1_base == CNT_MAX) ? CNT_MAX : w_ts1_base + CNT_W'(1);
                    else
                        w_ts1_nxt = w_consistent ? CNT_W'(1) : '0;
                    w_ts2_nxt = '0;
                end
                OS_TS2: begin
                    if (w_ident)
                        w_ts2_nxt = (w_ts2_base == CNT_MAX) ? CNT_MAX : w_ts2_base + CNT_W'(1);
                    else
                        w_ts2_nxt = w_consistent ? CNT_W'(1) : '0;
                    w_ts1_nxt = '0;
                end
                OS_SKP: begin
                end
                default: begin
                    w_ts1_nxt        = '0;
                    w_ts2_nxt        = '0;
                    w_hist_valid_nxt = 1'b0;
                end
            endcase
            if (w_is_ts && w_consistent) w_hist_valid_nxt = 1'b1;
        end
    end

    // Output, counter and history registers; reset drops any same-cycle set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_os_type    <= OS_NONE;
            r_link_num   <= '0;
            r_lane_num   <= '0;
            r_n_fts      <= '0;
            r_rate_id    <= '0;
            r_train_ctrl <= '0;
            r_link_pad   <= 1'b0;
            r_lane_pad   <= 1'b0;
            r_consistent <= 1'b0;
            r_ts1_count  <= '0;
            r_ts2_count  <= '0;
            r_ts1_rcvd8  <= 1'b0;
            r_ts2_rcvd8  <= 1'b0;
            r_hist_valid <= 1'b0;
            r_hist_type  <= OS_NONE;
            r_hist_body  <= '0;
        end else begin
            r_out_valid  <= os_valid;
            r_ts1_count  <= w_ts1_nxt;
            r_ts2_count  <= w_ts2_nxt;
            r_ts1_rcvd8  <= (32'(w_ts1_nxt) >= 32'd8);
            r_ts2_rcvd8  <= (32'(w_ts2_nxt) >= 32'd8);
            r_hist_valid <= w_hist_valid_nxt;
            if (os_valid) begin
                r_os_type    <= w_type;
                r_consistent <= w_consistent;
                if (w_is_ts) begin
                    r_link_num   <= w_syms[0][1];
                    r_lane_num   <= w_syms[0][2];
                    r_n_fts      <= w_syms[0][3];
                    r_rate_id    <= w_syms[0][4];
                    r_train_ctrl <= w_syms[0][5];
                    r_link_pad   <= (w_syms[0][1] == SYM_PAD);
                    r_lane_pad   <= (w_syms[0][2] == SYM_PAD);
                end
                if (w_is_ts && w_consistent) begin
                    r_hist_type <= w_type;
                    r_hist_body <= w_body;
                end
            end
        end
    end

    assign out_valid        = r_out_valid;
    assign os_type          = r_os_type;
    assign link_num         = r_link_num;
    assign lane_num         = r_lane_num;
    assign n_fts            = r_n_fts;
    assign rate_id          = r_rate_id;
    assign train_ctrl       = r_train_ctrl;
    assign link_pad         = r_link_pad;
    assign lane_pad         = r_lane_pad;
    assign lanes_consistent = r_consistent;
    assign ts1_count        = r_ts1_count;
    assign ts2_count        = r_ts2_count;
    assign ts1_rcvd8        = r_ts1_rcvd8;
    assign ts2_rcvd8        = r_ts2_rcvd8;

endmodule
